debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
Parametrised multi-channel debouncer for asynchronous board-level inputs such as push-buttons, external reset/enable straps and jumper lines. Each channel has its own synchroniser chain and stable-time counter. It produces a debounced level, single-cycle rise/fall strobes, a busy flag and a saturating glitch counter. The block sits between FPGA input pins and the capture control logic and supersedes single-channel reset-only debouncing.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
STABLE_CYCLES, 16, consecutive synchronised cycles an input must differ from dout before dout follows (>=2)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
INIT_LEVEL, {NUM_CH{1'b0}}, per-channel reset value of synchroniser flops and dout
GLITCH_W, 8, width of each per-channel glitch counter
(local) CNT_W = clog2(STABLE_CYCLES), stable counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
din  in  NUM_CH  raw asynchronous inputs, bit i = channel i
glitch_clr  in  1  synchronous clear of all glitch counters
dout  out  NUM_CH  debounced levels
rise  out  NUM_CH  1-cycle strobe when dout[i] goes 0->1
fall  out  NUM_CH  1-cycle strobe when dout[i] goes 1->0
busy  out  NUM_CH  high while channel i is counting a candidate transition
glitch_cnt  out  NUM_CH*GLITCH_W  per-channel aborted-transition counts; channel i at [i*GLITCH_W +: GLITCH_W]

Behaviour:
- Reset is synchronous; clk is the only clock. On a clk edge with rst=1: sync chain[i] and dout[i] = INIT_LEVEL[i]; cnt=0; rise=fall=0; busy=0; glitch_cnt=0. Reset is never held off by counting. No rise/fall strobe is emitted from a reset-induced dout change.
- Synchroniser: din[i] passes through SYNC_STAGES flops; s[i] is the last stage.
- Per channel, two states: IDLE (cnt==0) and COUNT (cnt!=0). All updates occur per clk edge with rst=0.
- IDLE, s==dout: hold.
- IDLE, s!=dout: cnt<=1.
- COUNT, s!=dout, cnt<STABLE_CYCLES-1: cnt<=cnt+1.
- COUNT, s!=dout, cnt==STABLE_CYCLES-1: dout<=s; cnt<=0; rise (0->1) or fall (1->0) <=1 for exactly one cycle, coincident with the new dout value.
- COUNT, s==dout (aborted transition): cnt<=0; glitch_cnt[i]<=glitch_cnt[i]+1, saturating at all-ones.
- rise/fall return to 0 on the following edge. rise and fall are never both high on one channel.
- busy[i] = (cnt[i]!=0), combinational from registered cnt.
- Latency: when din[i] changes before edge 1 and stays stable, dout[i] updates at edge SYNC_STAGES+STABLE_CYCLES.
- Minimum accepted pulse is STABLE_CYCLES synchronised cycles; shorter pulses are rejected and counted as glitches.
- glitch_clr=1 zeroes all glitch counters on that edge. It has priority over a simultaneous increment.
- rst has priority over everything.
- Channels are fully independent; simultaneous transitions on several channels are handled in parallel.

Test Plan:
- Reset release (NUM_CH=4, STABLE=4, SYNC=2, INIT=0, din=0): assert rst for 3 edges, release -> dout=0, rise/fall/busy=0, glitch_cnt=0, and no strobes for 20 cycles.
- Clean rise: din[0] 0->1 before edge 1, held -> dout[0]=1 at edge 6; rise[0]=1 only in cycle 6; busy[0] high edges 3-5; other channels unaffected.
- Glitch reject: din[1] high for 2 cycles only -> dout[1] stays 0, no strobe, glitch_cnt[1]=1. Repeat 300 times -> glitch_cnt[1] saturates at 255.
- Clean fall plus simultaneous multi-channel: ch0 1->0 and ch2 0->1 in the same cycle -> fall[0] and rise[2] both pulse at edge 6.
- Reset mid-count: din[3] rises, assert rst at edge 4 -> dout[3]=INIT, cnt=0, busy=0, no rise. After release with din[3] still 1 -> rise[3] 6 edges later.
- glitch_clr collision: assert glitch_clr on the same edge as an aborted transition on ch1 -> glitch_cnt[1]=0 afterwards.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel input debouncer for board-level signals.
// Each channel runs its own synchroniser and stable-time counter. It provides
// a debounced level, one-cycle rise/fall strobes, a busy flag and a
// saturating count of aborted (glitch) transitions.
module debounce_bank #(
    parameter int                NUM_CH        = 4,
    parameter int                STABLE_CYCLES = 16,
    parameter int                SYNC_STAGES   = 2,
    parameter logic [NUM_CH-1:0] INIT_LEVEL    = '0,
    parameter int                GLITCH_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            din,
    input  logic                         glitch_clr,
    output logic [NUM_CH-1:0]            dout,
    output logic [NUM_CH-1:0]            rise,
    output logic [NUM_CH-1:0]            fall,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH*GLITCH_W-1:0]   glitch_cnt
);

    localparam int                  CNT_W      = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    // A channel is counting exactly when its stable counter is non-zero.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } ch_state_e;

    logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]   sync_s;
    ch_state_e           state_s  [NUM_CH];
    logic [CNT_W-1:0]    cnt_q    [NUM_CH];
    logic [CNT_W-1:0]    cnt_d    [NUM_CH];
    logic [GLITCH_W-1:0] glitch_q [NUM_CH];
    logic [GLITCH_W-1:0] glitch_d [NUM_CH];
    logic [NUM_CH-1:0]   dout_q, dout_d;
    logic [NUM_CH-1:0]   rise_q, rise_d;
    logic [NUM_CH-1:0]   fall_q, fall_d;

    // Synchroniser chain: din enters stage 0, the last stage feeds the debounce logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT_LEVEL;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Decode per-channel state from the registered stable counter.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_s[i] = (cnt_q[i] == '0) ? ST_IDLE : ST_COUNT;
        end
    end

    // Next-state: start, extend, accept or abort a candidate transition per channel.
    always_comb begin
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            glitch_d[i] = glitch_q[i];
            unique case (state_s[i])
                ST_IDLE: begin
                    if (sync_s[i] != dout_q[i]) begin
                        cnt_d[i] = CNT_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (sync_s[i] == dout_q[i]) begin
                        // Input fell back before it was stable long enough.
                        cnt_d[i] = '0;
                        if (glitch_q[i] != GLITCH_MAX) begin
                            glitch_d[i] = glitch_q[i] + GLITCH_W'(1);
                        end
                    end else if (cnt_q[i] == CNT_LAST) begin
                        dout_d[i] = sync_s[i];
                        rise_d[i] = sync_s[i];
                        fall_d[i] = ~sync_s[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: cnt_d[i] = '0;
            endcase
            // Clearing wins over an increment on the same edge.
            if (glitch_clr) begin
                glitch_d[i] = '0;
            end
        end
    end

    // State registers; reset forces the initial level without emitting strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= INIT_LEVEL;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                glitch_q[i] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                glitch_q[i] <= glitch_d[i];
            end
        end
    end

    // Output mapping: busy is derived from the registered counter state.
    always_comb begin
        dout       = dout_q;
        rise       = rise_q;
        fall       = fall_q;
        busy       = '0;
        glitch_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i]                             = (state_s[i] == ST_COUNT);
            glitch_cnt[i*GLITCH_W +: GLITCH_W] = glitch_q[i];
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Testbench for debounce_bank: directed vector table, glitch saturation
// sequence and randomized stimulus against a sliding-window reference model.
module tb_debounce_bank;

    localparam int NCH  = 4;
    localparam int STB  = 4;
    localparam int SYNC = 2;
    localparam int GW   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    din = '0;
    logic              glitch_clr = 1'b0;
    logic [NCH-1:0]    dout, rise, fall, busy;
    logic [NCH*GW-1:0] glitch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    debounce_bank #(
        .NUM_CH(NCH), .STABLE_CYCLES(STB), .SYNC_STAGES(SYNC),
        .INIT_LEVEL('0), .GLITCH_W(GW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .glitch_clr(glitch_clr),
        .dout(dout), .rise(rise), .fall(fall), .busy(busy),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a channel follows its synchronised input once the last
    // STB samples all disagreed with the current level; a disagreeing run that
    // ends without reaching STB samples counts as one glitch.
    logic [NCH-1:0] dhist [SYNC];
    logic [STB-1:0] mwin  [NCH];
    logic [NCH-1:0] m_dout = '0, m_rise = '0, m_fall = '0;
    int             m_glitch [NCH];

    initial begin
        for (int k = 0; k < SYNC; k++) dhist[k] = '0;
        for (int c = 0; c < NCH; c++) begin
            mwin[c] = '0;
            m_glitch[c] = 0;
        end
    end

    always @(posedge clk) begin
        logic [NCH-1:0] s;
        logic diff, prev;
        if (rst) begin
            for (int k = 0; k < SYNC; k++) dhist[k] = '0;
            m_dout = '0; m_rise = '0; m_fall = '0;
            for (int c = 0; c < NCH; c++) begin
                mwin[c] = '0;
                m_glitch[c] = 0;
            end
        end else begin
            s = dhist[SYNC-1];
            for (int k = SYNC-1; k > 0; k--) dhist[k] = dhist[k-1];
            dhist[0] = din;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NCH; c++) begin
                diff = (s[c] != m_dout[c]);
                prev = mwin[c][0];
                mwin[c] = {mwin[c][STB-2:0], diff};
                if (&mwin[c]) begin
                    m_dout[c] = s[c];
                    m_rise[c] = s[c];
                    m_fall[c] = ~s[c];
                    mwin[c] = '0;
                end else if (!diff && prev) begin
                    m_glitch[c] = (m_glitch[c] >= 255) ? 255 : m_glitch[c] + 1;
                end
                if (glitch_clr) m_glitch[c] = 0;
            end
        end
    end

    function automatic logic [NCH*GW-1:0] model_gvec();
        logic [NCH*GW-1:0] v = '0;
        for (int c = 0; c < NCH; c++) v[c*GW +: GW] = GW'(m_glitch[c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] model_busy();
        logic [NCH-1:0] b = '0;
        for (int c = 0; c < NCH; c++) b[c] = mwin[c][0];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, ".dout"},   32'(dout),       32'(m_dout));
        chk({tag, ".rise"},   32'(rise),       32'(m_rise));
        chk({tag, ".fall"},   32'(fall),       32'(m_fall));
        chk({tag, ".busy"},   32'(busy),       32'(model_busy()));
        chk({tag, ".glitch"}, 32'(glitch_cnt), 32'(model_gvec()));
        chk({tag, ".rf_excl"}, 32'(rise & fall), 32'h0);
    endtask

    // Apply inputs away from the edge, advance one edge, sample 1 time unit later.
    task automatic step(input logic [NCH-1:0] d, input logic gc, input logic r);
        din = d;
        glitch_clr = gc;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NCH-1:0] din;
        logic           gclr;
        logic           rst;
        logic [NCH-1:0] dout;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] busy;
        logic [31:0]    gcnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] d, input logic gc, input logic r,
                                input logic [3:0] o, input logic [3:0] ri,
                                input logic [3:0] fa, input logic [3:0] b,
                                input logic [31:0] g);
        vec_t v;
        v.din = d; v.gclr = gc; v.rst = r; v.dout = o; v.rise = ri;
        v.fall = fa; v.busy = b; v.gcnt = g;
        tbl.push_back(v);
    endfunction

    initial begin
        // Clean rise on ch0: accepted at edge SYNC+STB = 6.
        add(4'b0001,0,0, 4'b0000,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0001,0,0, 4'b0000,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0001,0,0, 4'b0000,4'b0000,4'b0000,4'b0001, 32'h0);
        add(4'b0001,0,0, 4'b0000,4'b0000,4'b0000,4'b0001, 32'h0);
        add(4'b0001,0,0, 4'b0000,4'b0000,4'b0000,4'b0001, 32'h0);
        add(4'b0001,0,0, 4'b0001,4'b0001,4'b0000,4'b0000, 32'h0);
        add(4'b0001,0,0, 4'b0001,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0001,0,0, 4'b0001,4'b0000,4'b0000,4'b0000, 32'h0);
        // ch0 falls and ch2 rises together.
        add(4'b0100,0,0, 4'b0001,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0100,0,0, 4'b0001,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0100,0,0, 4'b0001,4'b0000,4'b0000,4'b0101, 32'h0);
        add(4'b0100,0,0, 4'b0001,4'b0000,4'b0000,4'b0101, 32'h0);
        add(4'b0100,0,0, 4'b0001,4'b0000,4'b0000,4'b0101, 32'h0);
        add(4'b0100,0,0, 4'b0100,4'b0100,4'b0001,4'b0000, 32'h0);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h0);
        // 2-cycle pulse on ch1: rejected, one glitch counted.
        add(4'b0110,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0110,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0010, 32'h0);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0010, 32'h0);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h100);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h100);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h100);
        // Second ch1 glitch aborts on the same edge as glitch_clr: clear wins.
        add(4'b0110,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h100);
        add(4'b0110,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h100);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0010, 32'h100);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0010, 32'h100);
        add(4'b0100,1,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b0100,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h0);
        // ch3 rises, reset hits mid-count; ch2 drops to INIT without a fall strobe.
        add(4'b1100,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b1100,0,0, 4'b0100,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b1100,0,0, 4'b0100,4'b0000,4'b0000,4'b1000, 32'h0);
        add(4'b1100,0,1, 4'b0000,4'b0000,4'b0000,4'b0000, 32'h0);
        // After release ch2 and ch3 re-qualify and strobe 6 edges later.
        add(4'b1100,0,0, 4'b0000,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b1100,0,0, 4'b0000,4'b0000,4'b0000,4'b0000, 32'h0);
        add(4'b1100,0,0, 4'b0000,4'b0000,4'b0000,4'b1100, 32'h0);
        add(4'b1100,0,0, 4'b0000,4'b0000,4'b0000,4'b1100, 32'h0);
        add(4'b1100,0,0, 4'b0000,4'b0000,4'b0000,4'b1100, 32'h0);
        add(4'b1100,0,0, 4'b1100,4'b1100,4'b0000,4'b0000, 32'h0);
        add(4'b1100,0,0, 4'b1100,4'b0000,4'b0000,4'b0000, 32'h0);

        // Reset release: three reset edges, then quiet for 20 cycles.
        for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b1);
        chk("rst.dout",   32'(dout), 32'h0);
        chk("rst.rise",   32'(rise), 32'h0);
        chk("rst.fall",   32'(fall), 32'h0);
        chk("rst.busy",   32'(busy), 32'h0);
        chk("rst.glitch", 32'(glitch_cnt), 32'h0);
        for (int k = 0; k < 20; k++) begin
            step('0, 1'b0, 1'b0);
            chk("idle.strobe", 32'(rise | fall), 32'h0);
            model_cmp("idle");
        end

        // Directed vector table.
        foreach (tbl[k]) begin
            string tag;
            step(tbl[k].din, tbl[k].gclr, tbl[k].rst);
            tag = $sformatf("vec%0d", k);
            chk({tag, ".dout"},   32'(dout),       32'(tbl[k].dout));
            chk({tag, ".rise"},   32'(rise),       32'(tbl[k].rise));
            chk({tag, ".fall"},   32'(fall),       32'(tbl[k].fall));
            chk({tag, ".busy"},   32'(busy),       32'(tbl[k].busy));
            chk({tag, ".glitch"}, 32'(glitch_cnt), tbl[k].gcnt);
            model_cmp(tag);
        end

        // 300 short pulses on ch1: counter must saturate at 255.
        for (int n = 0; n < 300; n++) begin
            step(4'b1110, 1'b0, 1'b0);
            step(4'b1110, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                step(4'b1100, 1'b0, 1'b0);
                chk("sat.strobe", 32'(rise | fall), 32'h0);
            end
        end
        chk("sat.glitch1", 32'(glitch_cnt[15:8]), 32'hff);
        chk("sat.others",  32'({glitch_cnt[31:16], glitch_cnt[7:0]}), 32'h0);
        chk("sat.dout",    32'(dout), 32'b1100);
        model_cmp("sat");

        // Randomized stimulus with occasional clears and resets.
        begin
            logic [NCH-1:0] d;
            d = din;
            for (int k = 0; k < 3000; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
                end
                step(d, ($urandom_range(0, 63) == 0), ($urandom_range(0, 299) == 0));
                model_cmp("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
